// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: responder for an HD44780-style 8-bit LCD write bus.
// Holds a 2x16 visible DDRAM image, the address counter, display flags and a busy model.
module lcd_bus_receiver #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic [4:0] iRD_ADDR,
    output logic [7:0] oRD_CHAR,
    output logic [6:0] oADDR,
    output logic       oBUSY,
    output logic       oDISP_ON,
    output logic       oCURSOR_ON,
    output logic       oBLINK_ON,
    output logic       oTWO_LINE,
    output logic       oEIGHT_BIT,
    output logic       oWR_STROBE,
    output logic       oCMD_ERR
);
    localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] FILL_LOAD  = CW'(31);

    typedef enum logic [1:0] {IDLE, EXEC, CLR} stateT;

    logic [10:0]   r_sync1, r_sync2;
    logic          r_enPrev, r_fall, r_cmdRs, r_cmdRw;
    logic [7:0]    r_cmdData;
    stateT         r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_fillIdx;
    logic [6:0]    r_addr;
    logic          r_id, r_busy, r_dispOn, r_cursorOn, r_blinkOn;
    logic          r_twoLine, r_eightBit, r_wrStrobe, r_cmdErr;
    logic [7:0]    r_ddram [32];
    logic [7:0]    r_rdChar;

    logic          w_fall, w_accept, w_visible, w_memWe;
    logic [4:0]    w_cell, w_memAddr;
    logic [7:0]    w_memData;

    // Address ring is 0x00..0x27 then 0x40..0x67; anything else steps by plain +/-1.
    function automatic logic [6:0] stepAddr(input logic [6:0] a, input logic up);
        logic [6:0] n;
        if (up) n = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else    n = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        return n;
    endfunction

    // All bus lines share one synchroniser so data stays aligned with EN.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_enPrev  <= 1'b0;
            r_fall    <= 1'b0;
            r_cmdRs   <= 1'b0;
            r_cmdRw   <= 1'b0;
            r_cmdData <= '0;
        end else begin
            r_sync1   <= {LCD_EN, LCD_RS, LCD_RW, LCD_DATA};
            r_sync2   <= r_sync1;
            r_enPrev  <= r_sync2[10];
            r_fall    <= w_fall;
            r_cmdRs   <= r_sync2[9];
            r_cmdRw   <= r_sync2[8];
            r_cmdData <= r_sync2[7:0];
        end
    end

    assign w_fall    = r_enPrev & ~r_sync2[10];
    assign w_accept  = r_fall & ~r_busy & ~r_cmdRw;
    assign w_visible = (r_addr[5:4] == 2'b00);
    assign w_cell    = {r_addr[6], r_addr[3:0]};
    assign w_memWe   = ~iRST & ((r_state == CLR) | (w_accept & r_cmdRs & w_visible));
    assign w_memAddr = (r_state == CLR) ? r_fillIdx : w_cell;
    assign w_memData = (r_state == CLR) ? 8'h20 : r_cmdData;

    // Every accepted transaction defaults to a BUSY_CYCLES stay in EXEC; clear, home and no-op override it.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= CLR;
            r_busy     <= 1'b1;
            r_cnt      <= FILL_LOAD;
            r_fillIdx  <= '0;
            r_addr     <= '0;
            r_id       <= 1'b1;
            r_eightBit <= 1'b1;
            r_twoLine  <= 1'b0;
            r_dispOn   <= 1'b0;
            r_cursorOn <= 1'b0;
            r_blinkOn  <= 1'b0;
            r_wrStrobe <= 1'b0;
            r_cmdErr   <= 1'b0;
        end else begin
            r_wrStrobe <= 1'b0;
            if (r_fall && (r_busy || r_cmdRw))
                r_cmdErr <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= EXEC;
                        r_busy  <= 1'b1;
                        r_cnt   <= BUSY_LOAD;
                        if (r_cmdRs) begin
                            r_addr     <= stepAddr(r_addr, r_id);
                            r_wrStrobe <= 1'b1;
                        end else begin
                            casez (r_cmdData)
                                8'b1???????: r_addr <= r_cmdData[6:0];
                                8'b01??????: ;
                                8'b001?????: begin
                                    r_eightBit <= r_cmdData[4];
                                    r_twoLine  <= r_cmdData[3];
                                end
                                8'b0001????: begin
                                    if (!r_cmdData[3])
                                        r_addr <= stepAddr(r_addr, r_cmdData[2]);
                                end
                                8'b00001???: begin
                                    r_dispOn   <= r_cmdData[2];
                                    r_cursorOn <= r_cmdData[1];
                                    r_blinkOn  <= r_cmdData[0];
                                end
                                // The S bit has no observable effect, so only I/D is kept.
                                8'b000001??: r_id <= r_cmdData[1];
                                8'b0000001?: begin
                                    r_addr <= '0;
                                    r_cnt  <= CLEAR_LOAD;
                                end
                                8'b00000001: begin
                                    r_addr    <= '0;
                                    r_id      <= 1'b1;
                                    r_cnt     <= CLEAR_LOAD;
                                    r_fillIdx <= '0;
                                    r_state   <= CLR;
                                end
                                default: begin
                                    r_state <= IDLE;
                                    r_busy  <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                CLR: begin
                    r_fillIdx <= r_fillIdx + 5'd1;
                    if (r_fillIdx == 5'd31 && r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_fillIdx == 5'd31)
                            r_state <= EXEC;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_memWe)
            r_ddram[w_memAddr] <= w_memData;
    end

    // Read-before-write: a same-cycle write to the read cell returns the old value.
    always_ff @(posedge iCLK) begin
        if (iRST) r_rdChar <= 8'h00;
        else      r_rdChar <= r_ddram[iRD_ADDR];
    end

    assign oRD_CHAR   = r_rdChar;
    assign oADDR      = r_addr;
    assign oBUSY      = r_busy;
    assign oDISP_ON   = r_dispOn;
    assign oCURSOR_ON = r_cursorOn;
    assign oBLINK_ON  = r_blinkOn;
    assign oTWO_LINE  = r_twoLine;
    assign oEIGHT_BIT = r_eightBit;
    assign oWR_STROBE = r_wrStrobe;
    assign oCMD_ERR   = r_cmdErr;
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: directed bench for lcd_bus_receiver with short busy timings.
// Drives on negedge, samples on negedge; expected values are hand-computed constants.
module tb_lcd_bus_receiver;
    localparam int BUSY_N  = 4;
    localparam int CLEAR_N = 40;

    logic       iCLK;
    logic       iRST;
    logic [7:0] LCD_DATA;
    logic       LCD_RS, LCD_RW, LCD_EN;
    logic [4:0] iRD_ADDR;
    logic [7:0] oRD_CHAR;
    logic [6:0] oADDR;
    logic       oBUSY, oDISP_ON, oCURSOR_ON, oBLINK_ON;
    logic       oTWO_LINE, oEIGHT_BIT, oWR_STROBE, oCMD_ERR;

    int compared   = 0;
    int mismatched = 0;

    lcd_bus_receiver #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
        .iCLK(iCLK), .iRST(iRST), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .iRD_ADDR(iRD_ADDR), .oRD_CHAR(oRD_CHAR),
        .oADDR(oADDR), .oBUSY(oBUSY), .oDISP_ON(oDISP_ON), .oCURSOR_ON(oCURSOR_ON),
        .oBLINK_ON(oBLINK_ON), .oTWO_LINE(oTWO_LINE), .oEIGHT_BIT(oEIGHT_BIT),
        .oWR_STROBE(oWR_STROBE), .oCMD_ERR(oCMD_ERR)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One bus transaction; returns at the first negedge after its effects land.
    task automatic applyStimulus(input logic rs, input logic rw, input logic [7:0] data);
        @(negedge iCLK);
        LCD_RS   = rs;
        LCD_RW   = rw;
        LCD_DATA = data;
        LCD_EN   = 1'b1;
        repeat (4) @(negedge iCLK);
        LCD_EN = 1'b0;
        repeat (4) @(negedge iCLK);
    endtask

    // Counts negedge samples with oBUSY high, starting at the current one.
    task automatic checkBusy(input string tag, input int expected);
        int n;
        n = 0;
        while (oBUSY === 1'b1 && n < 200) begin
            n++;
            @(negedge iCLK);
        end
        checkOutput(tag, n, expected);
    endtask

    task automatic checkCell(input string tag, input logic [4:0] idx, input logic [7:0] expected);
        @(negedge iCLK);
        iRD_ADDR = idx;
        @(negedge iCLK);
        checkOutput(tag, oRD_CHAR, expected);
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "Busy"},   oBUSY,      1);
        checkOutput({pfx, "Addr"},   oADDR,      0);
        checkOutput({pfx, "Eight"},  oEIGHT_BIT, 1);
        checkOutput({pfx, "Two"},    oTWO_LINE,  0);
        checkOutput({pfx, "Disp"},   oDISP_ON,   0);
        checkOutput({pfx, "Cursor"}, oCURSOR_ON, 0);
        checkOutput({pfx, "Blink"},  oBLINK_ON,  0);
        checkOutput({pfx, "Strobe"}, oWR_STROBE, 0);
        checkOutput({pfx, "Err"},    oCMD_ERR,   0);
        checkOutput({pfx, "RdChar"}, oRD_CHAR,   8'h00);
    endtask

    initial begin
        iRST = 1'b1; LCD_EN = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0;
        LCD_DATA = 8'h00; iRD_ADDR = 5'd0;
        repeat (3) @(negedge iCLK);
        checkResetValues("rst");
        iRST = 1'b0;
        checkBusy("rstFillBusy", 32);
        for (int i = 0; i < 32; i++)
            checkCell($sformatf("initCell%0d", i), 5'(i), 8'h20);

        applyStimulus(0, 0, 8'h38); checkBusy("busy38", BUSY_N);
        applyStimulus(0, 0, 8'h0C); checkBusy("busy0C", BUSY_N);
        applyStimulus(0, 0, 8'h01); checkBusy("busyClear", CLEAR_N);
        applyStimulus(0, 0, 8'h06); checkBusy("busy06", BUSY_N);
        applyStimulus(0, 0, 8'h80); checkBusy("busy80", BUSY_N);
        checkOutput("twoLine",  oTWO_LINE,  1);
        checkOutput("eightBit", oEIGHT_BIT, 1);
        checkOutput("dispOn",   oDISP_ON,   1);
        checkOutput("cursorOn", oCURSOR_ON, 0);
        checkOutput("blinkOn",  oBLINK_ON,  0);
        checkOutput("addrInit", oADDR,      7'h00);

        applyStimulus(1, 0, 8'h50);
        checkOutput("strobe50", oWR_STROBE, 1);
        checkOutput("busyHi50", oBUSY, 1);
        checkBusy("busy50", BUSY_N);
        applyStimulus(0, 0, 8'h88); checkBusy("busy88", BUSY_N);
        applyStimulus(1, 0, 8'h31);
        checkOutput("strobe31", oWR_STROBE, 1);
        @(negedge iCLK);
        checkOutput("strobe31End", oWR_STROBE, 0);
        checkBusy("busy31", BUSY_N - 1);
        checkOutput("addr09", oADDR, 7'h09);
        checkCell("cell0is50", 5'd0, 8'h50);
        checkCell("cell8is31", 5'd8, 8'h31);

        applyStimulus(0, 0, 8'hA7); checkBusy("busyA7", BUSY_N);
        checkOutput("addr27", oADDR, 7'h27);
        applyStimulus(1, 0, 8'h41);
        checkOutput("strobe41", oWR_STROBE, 1);
        checkBusy("busy41", BUSY_N);
        checkOutput("addrWrap40", oADDR, 7'h40);
        checkCell("cell0keep", 5'd0, 8'h50);
        checkCell("cell8keep", 5'd8, 8'h31);
        checkCell("cell16keep", 5'd16, 8'h20);
        applyStimulus(1, 0, 8'h42); checkBusy("busy42", BUSY_N);
        checkCell("cell16is42", 5'd16, 8'h42);
        checkOutput("addr41", oADDR, 7'h41);
        applyStimulus(0, 0, 8'h04); checkBusy("busy04", BUSY_N);
        applyStimulus(0, 0, 8'h80); checkBusy("busy80b", BUSY_N);
        applyStimulus(1, 0, 8'h43); checkBusy("busy43", BUSY_N);
        checkCell("cell0is43", 5'd0, 8'h43);
        checkOutput("addrWrap67", oADDR, 7'h67);

        // Return home keeps the block busy long enough to land a write on it.
        applyStimulus(0, 0, 8'h02);
        checkOutput("homeAddr", oADDR, 7'h00);
        checkOutput("homeBusy", oBUSY, 1);
        applyStimulus(1, 0, 8'h58);
        checkOutput("errBusyWr", oCMD_ERR, 1);
        checkOutput("noStrobeBusy", oWR_STROBE, 0);
        checkBusy("busyHomeRest", CLEAR_N - 9);
        checkOutput("addrAfterRej", oADDR, 7'h00);
        checkCell("cell0afterRej", 5'd0, 8'h43);
        applyStimulus(1, 1, 8'h59);
        checkOutput("rwNotBusy", oBUSY, 0);
        checkOutput("rwErrSticky", oCMD_ERR, 1);
        checkOutput("rwNoStrobe", oWR_STROBE, 0);
        checkOutput("rwAddr", oADDR, 7'h00);
        checkCell("cell0afterRw", 5'd0, 8'h43);

        applyStimulus(0, 0, 8'h00);
        checkOutput("nopNotBusy", oBUSY, 0);
        applyStimulus(0, 0, 8'h14); checkBusy("busy14", BUSY_N);
        checkOutput("shiftRight", oADDR, 7'h01);
        applyStimulus(0, 0, 8'h10); checkBusy("busy10a", BUSY_N);
        checkOutput("shiftLeft", oADDR, 7'h00);
        applyStimulus(0, 0, 8'h10); checkBusy("busy10b", BUSY_N);
        checkOutput("shiftLeftWrap", oADDR, 7'h67);
        applyStimulus(0, 0, 8'h18); checkBusy("busy18", BUSY_N);
        checkOutput("dispShiftNop", oADDR, 7'h67);

        // Abort a clear part-way through its fill.
        applyStimulus(0, 0, 8'h01);
        repeat (9) @(negedge iCLK);
        iRST = 1'b1;
        repeat (2) @(negedge iCLK);
        checkResetValues("abort");
        iRST = 1'b0;
        checkBusy("abortFillBusy", 32);
        checkCell("abortCell0", 5'd0, 8'h20);
        checkCell("abortCell8", 5'd8, 8'h20);
        checkCell("abortCell16", 5'd16, 8'h20);
        checkCell("abortCell31", 5'd31, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
